// File: rtl/i2c_reg_bank_pkg.sv
// Shared constants and address-map helpers for the I2C register bank.
package i2c_reg_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // STATUS sits right after the RW block and the RO block
  function automatic int unsigned status_ofs(input int unsigned num_rw, input int unsigned num_ro);
    return num_rw + num_ro;
  endfunction

  function automatic int unsigned irqen_ofs(input int unsigned num_rw, input int unsigned num_ro);
    return status_ofs(num_rw, num_ro) + 1;
  endfunction

  // Highest mapped address; the auto-increment pointer wraps after it
  function automatic int unsigned reg_top(input int unsigned num_rw, input int unsigned num_ro);
    return irqen_ofs(num_rw, num_ro);
  endfunction

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Byte-level register access channel between the I2C slave front end and the bank.
interface i2c_reg_bank_if
  import i2c_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] addr;
  logic              addrLoad;
  logic [DATA_W-1:0] dataIn;
  logic              writeEn;
  logic              readEn;
  logic [DATA_W-1:0] dataOut;

  modport master (
    output addr, addrLoad, dataIn, writeEn, readEn,
    input  dataOut
  );

  modport slave (
    input  addr, addrLoad, dataIn, writeEn, readEn,
    output dataOut
  );
endinterface

// File: rtl/i2c_reg_bank_status_reg.sv
// Sticky event STATUS register with write-one-to-clear, IRQ enable mask and registered irq.
module i2c_status_reg
  import i2c_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] status_in,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr_status,
  input  logic              wr_irq_en,
  output logic [DATA_W-1:0] status_next_c,
  output logic [DATA_W-1:0] irq_en_next_c,
  output logic              irq
);

  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] irq_en;

  // W1C applied first so a same-cycle event re-sets the bit
  always_comb begin
    status_next_c = status;
    irq_en_next_c = irq_en;
    if (wr_status) begin
      status_next_c = status & ~wdata;
    end
    status_next_c = status_next_c | status_in;
    if (wr_irq_en) begin
      irq_en_next_c = wdata;
    end
  end

  // irq follows the register values being loaded this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      status <= status_next_c;
      irq_en <= irq_en_next_c;
      irq    <= |(status_next_c & irq_en_next_c);
    end
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C-addressed register bank: RW control registers, RO status inputs, sticky STATUS
// with IRQ mask, and an auto-incrementing access pointer for burst transfers.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int unsigned NUM_RW = 4,
  parameter int unsigned NUM_RO = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  i2c_reg_bank_if.slave                              bus,
  input  logic [(NUM_RO > 0 ? NUM_RO : 1)*DATA_W-1:0] roIn,
  input  logic [DATA_W-1:0]                          statusIn,
  output logic [NUM_RW*DATA_W-1:0]                   rwOut,
  output logic [NUM_RW-1:0]                          wrStrobe,
  output logic                                       irq
);

  localparam int unsigned STATUS_OFS = status_ofs(NUM_RW, NUM_RO);
  localparam int unsigned IRQEN_OFS  = irqen_ofs(NUM_RW, NUM_RO);
  localparam int unsigned REG_TOP    = reg_top(NUM_RW, NUM_RO);

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] eff;
  logic [ADDR_W-1:0] ptr_next;
  logic              access;

  logic [DATA_W-1:0] rw_q    [NUM_RW];
  logic [DATA_W-1:0] rw_next [NUM_RW];
  logic [NUM_RW-1:0] wr_hit;

  logic              wr_status;
  logic              wr_irq_en;
  logic [DATA_W-1:0] status_next;
  logic [DATA_W-1:0] irq_en_next;
  logic [DATA_W-1:0] rd_data;

  // Effective address and auto-increment pointer with wrap past REG_TOP
  always_comb begin
    eff      = bus.addrLoad ? bus.addr : ptr;
    access   = bus.writeEn | bus.readEn;
    ptr_next = eff;
    if (access) begin
      ptr_next = (eff >= ADDR_W'(REG_TOP)) ? '0 : eff + ADDR_W'(1);
    end
  end

  // Write decode; RO and unmapped addresses fall through with no effect
  always_comb begin
    wr_hit    = '0;
    wr_status = bus.writeEn && (eff == ADDR_W'(STATUS_OFS));
    wr_irq_en = bus.writeEn && (eff == ADDR_W'(IRQEN_OFS));
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      rw_next[i] = rw_q[i];
      if (bus.writeEn && (eff == ADDR_W'(i))) begin
        wr_hit[i]  = 1'b1;
        rw_next[i] = bus.dataIn;
      end
    end
  end

  i2c_status_reg #(
    .DATA_W (DATA_W)
  ) u_status (
    .clk           (clk),
    .rst           (rst),
    .status_in     (statusIn),
    .wdata         (bus.dataIn),
    .wr_status     (wr_status),
    .wr_irq_en     (wr_irq_en),
    .status_next_c (status_next),
    .irq_en_next_c (irq_en_next),
    .irq           (irq)
  );

  // Read mux uses post-write values so a just-written register is never stale
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_RW; i++) begin
      if (ptr_next == ADDR_W'(i)) begin
        rd_data = rw_next[i];
      end
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (ptr_next == ADDR_W'(NUM_RW + k)) begin
        rd_data = roIn[k*DATA_W +: DATA_W];
      end
    end
    if (ptr_next == ADDR_W'(STATUS_OFS)) begin
      rd_data = status_next;
    end
    if (ptr_next == ADDR_W'(IRQEN_OFS)) begin
      rd_data = irq_en_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      bus.dataOut <= '0;
      wrStrobe    <= '0;
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        rw_q[i] <= '0;
      end
    end else begin
      ptr         <= ptr_next;
      bus.dataOut <= rd_data;
      wrStrobe    <= wr_hit;
      for (int unsigned i = 0; i < NUM_RW; i++) begin
        rw_q[i] <= rw_next[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_RW); g++) begin : g_rw_out
    assign rwOut[g*DATA_W +: DATA_W] = rw_q[g];
  end

endmodule
